// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and GF(2^8) helper functions
// used by the inverse cipher and its sbox word sub-module.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, SUB, ADD} aes_state_t;

  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  // Byte x of each table lives at bits [2047-8*x -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*x -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX_TBL[2047 - 8*x -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Byte 0 is the MSB; the state is column-major (byte 4*c+r is row r of column c).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      res[127 - 32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
      };
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Substitutes the four bytes of a 32-bit word through the forward or
// inverse AES sbox, selected at elaboration by INVERSE.
module aes_sbox_word import aes_pkg::*; #(
  parameter bit INVERSE = 1'b0
) (
  input  logic [31:0] data,
  output logic [31:0] result
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign result[8*i +: 8] = INVERSE ? inv_sbox(data[8*i +: 8]) : sbox(data[8*i +: 8]);
  end

endmodule

// File: rtl/aes_dec.sv
// Iterative AES-128 inverse cipher: starts from round key 10 and runs the
// key expansion backwards, one SUB/ADD pair per round.
module aes_dec import aes_pkg::*; #(
  parameter int unsigned FAST_MODE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_aes_key,
  input  logic [127:0] s_aes_block,
  input  logic         s_aes_valid,
  output logic         s_aes_ready,
  output logic [127:0] m_aes_block,
  output logic         m_aes_valid,
  output logic [3:0]   round,
  output logic [127:0] round_key
);

  aes_state_t   state;
  logic [127:0] block;
  logic [7:0]   rcon;
  logic [1:0]   word_cnt;

  logic [127:0] sub_next;
  logic         sub_last;
  logic [127:0] add_t;

  assign s_aes_ready = (state == IDLE) && !rst;
  assign add_t       = block ^ round_key;

  // Inverse key step: recover the previous round key from the current one.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  kw1, kw2, kw3, key_sub;
  logic [127:0] rkey_next;
  logic [7:0]   rcon_next;

  assign {w0, w1, w2, w3} = round_key;
  assign kw3 = w3 ^ w2;
  assign kw2 = w2 ^ w1;
  assign kw1 = w1 ^ w0;

  aes_sbox_word #(.INVERSE(1'b0)) u_key_sbox (
    .data   ({kw3[23:0], kw3[31:24]}),
    .result (key_sub)
  );

  assign rkey_next = {w0 ^ key_sub ^ {rcon, 24'h0}, kw1, kw2, kw3};
  assign rcon_next = ((rcon & RCON_FIRST) != '0) ? (((rcon ^ 8'h1b) >> 1) | 8'h80)
                                                 : (rcon >> 1);

  if (FAST_MODE != 0) begin : g_fast
    logic [127:0] shifted;
    assign shifted  = inv_shift_rows(block);
    assign sub_last = 1'b1;
    for (genvar i = 0; i < 4; i++) begin : g_word
      aes_sbox_word #(.INVERSE(1'b1)) u_sbox (
        .data   (shifted[127 - 32*i -: 32]),
        .result (sub_next[127 - 32*i -: 32])
      );
    end
  end else begin : g_slow
    // Words are substituted in place and the row shift is applied on the last
    // word, so later words never read bytes already overwritten this round.
    logic [31:0]  cur, cur_sub;
    logic [127:0] merged;

    always_comb begin
      unique case (word_cnt)
        2'd0:    cur = block[127:96];
        2'd1:    cur = block[95:64];
        2'd2:    cur = block[63:32];
        default: cur = block[31:0];
      endcase
    end

    aes_sbox_word #(.INVERSE(1'b1)) u_sbox (
      .data   (cur),
      .result (cur_sub)
    );

    always_comb begin
      merged = block;
      unique case (word_cnt)
        2'd0:    merged[127:96] = cur_sub;
        2'd1:    merged[95:64]  = cur_sub;
        2'd2:    merged[63:32]  = cur_sub;
        default: merged[31:0]   = cur_sub;
      endcase
    end

    assign sub_last = (word_cnt == 2'd3);
    assign sub_next = sub_last ? inv_shift_rows(merged) : merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      block       <= '0;
      round_key   <= '0;
      round       <= '0;
      rcon        <= '0;
      word_cnt    <= '0;
      m_aes_block <= '0;
      m_aes_valid <= 1'b0;
    end else begin
      m_aes_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s_aes_valid) begin
            block     <= s_aes_block ^ s_aes_key;
            round_key <= s_aes_key;
            round     <= 4'd10;
            rcon      <= RCON_LAST;
            word_cnt  <= '0;
            state     <= SUB;
          end
        end
        SUB: begin
          block <= sub_next;
          if (sub_last) begin
            word_cnt  <= '0;
            round_key <= rkey_next;
            rcon      <= rcon_next;
            round     <= round - 4'd1;
            state     <= ADD;
          end else begin
            word_cnt <= word_cnt + 2'd1;
          end
        end
        ADD: begin
          if (round != 4'd0) begin
            block <= inv_mix_columns(add_t);
            state <= SUB;
          end else begin
            m_aes_block <= add_t;
            m_aes_valid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
